pipe_control_unit: RTL and testbench

- Pipelined, parametrised control unit for the 5-stage MIPS core.
- Decodes opcode/func in ID, then carries the control word through registered ID/EX, EX/MEM and MEM/WB stages.
- Inserts bubbles on hazard stall or flush.
- Runs a multi-cycle mult/div sequencer that stalls dependent HI/LO instructions until the operation completes.

---
 rtl/pipe_control_unit.sv | 216 +++++++++++++++++++++
 tb/tb_pipe_control_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_control_unit
// Brief    : Pipelined MIPS control unit with ID decode, ID/EX-EX/MEM-MEM/WB
//            control registers and a multi-cycle mult/div busy sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_control_unit #(
    parameter int MULT_LATENCY = 4,
    parameter int DIV_LATENCY  = 8,
    parameter int CNT_W        = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       instr_valid_d,
    input  logic [5:0] opcode_d,
    input  logic [5:0] func_d,
    input  logic       hazard_stall_d,
    input  logic       flush_e,
    output logic       branch_d,
    output logic       jump_d,
    output logic       if_flush_d,
    output logic       stall_fd,
    output logic       alu_src_e,
    output logic [1:0] alu_op_e,
    output logic [1:0] reg_dst_e,
    output logic       muldiv_start_e,
    output logic       mem_write_m,
    output logic       reg_write_m,
    output logic       reg_write_w,
    output logic       mem_to_reg_w,
    output logic       memory_src_w,
    output logic       muldiv_busy,
    output logic       muldiv_done
);

    localparam logic [0:0]       c_IDLE     = 1'b0;
    localparam logic [0:0]       c_BUSY     = 1'b1;
    localparam logic [CNT_W-1:0] c_MULT_CNT = CNT_W'(MULT_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_DIV_CNT  = CNT_W'(DIV_LATENCY - 1);

    logic       w_branch, w_jump, w_ifFlush, w_aluSrc;
    logic [1:0] w_aluOp, w_regDst;
    logic       w_regWrite, w_memWrite, w_memToReg, w_memSrc;
    logic       w_muldiv, w_usesHilo, w_isDiv;
    logic       w_muldivStall, w_bubble;

    logic       r_aluSrcE, r_regWriteE, r_memWriteE, r_memToRegE, r_memSrcE;
    logic [1:0] r_aluOpE, r_regDstE;
    logic       r_muldivE, r_isDivE;
    logic       r_memWriteM, r_regWriteM, r_memToRegM, r_memSrcM;
    logic       r_regWriteW, r_memToRegW, r_memSrcW;
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    always_comb begin
        w_branch   = 1'b0;
        w_jump     = 1'b0;
        w_ifFlush  = 1'b0;
        w_aluSrc   = 1'b0;
        w_aluOp    = 2'b00;
        w_regDst   = 2'b00;
        w_regWrite = 1'b0;
        w_memWrite = 1'b0;
        w_memToReg = 1'b0;
        w_memSrc   = 1'b0;
        w_muldiv   = 1'b0;
        w_usesHilo = 1'b0;
        w_isDiv    = 1'b0;
        if (instr_valid_d) begin
            case (opcode_d)
                6'b000000: begin
                    // R-type baseline; the func cases below override it
                    w_regDst   = 2'b01;
                    w_aluOp    = 2'b10;
                    w_regWrite = 1'b1;
                    case (func_d)
                        6'b001000: begin
                            w_jump     = 1'b1;
                            w_ifFlush  = 1'b1;
                            w_aluOp    = 2'b01;
                            w_regWrite = 1'b0;
                        end
                        6'b011000, 6'b011001: begin
                            w_muldiv   = 1'b1;
                            w_regWrite = 1'b0;
                        end
                        6'b011010, 6'b011011: begin
                            w_muldiv   = 1'b1;
                            w_isDiv    = 1'b1;
                            w_regWrite = 1'b0;
                        end
                        6'b010000, 6'b010010: w_usesHilo = 1'b1;
                        default: ;
                    endcase
                end
                6'b100011: begin
                    w_aluSrc   = 1'b1;
                    w_regWrite = 1'b1;
                    w_memToReg = 1'b1;
                end
                6'b101011: begin
                    w_aluSrc   = 1'b1;
                    w_memWrite = 1'b1;
                end
                6'b000100: begin
                    w_branch = 1'b1;
                    w_aluOp  = 2'b01;
                end
                6'b000101: begin
                    w_branch = 1'b1;
                    w_aluOp  = 2'b11;
                end
                6'b000010: begin
                    w_jump    = 1'b1;
                    w_ifFlush = 1'b1;
                    w_aluSrc  = 1'b1;
                end
                6'b000011: begin
                    w_jump     = 1'b1;
                    w_ifFlush  = 1'b1;
                    w_regDst   = 2'b10;
                    w_regWrite = 1'b1;
                    w_memSrc   = 1'b1;
                end
                default: begin
                    w_aluSrc   = 1'b1;
                    w_aluOp    = 2'b11;
                    w_regWrite = 1'b1;
                end
            endcase
        end
    end

    assign w_muldivStall = muldiv_busy & (w_muldiv | w_usesHilo);
    assign stall_fd      = hazard_stall_d | w_muldivStall;
    assign w_bubble      = stall_fd | flush_e;

    // Redirects are suppressed while ID is held so they fire once, on issue
    assign branch_d   = w_branch  & ~stall_fd;
    assign jump_d     = w_jump    & ~stall_fd;
    assign if_flush_d = w_ifFlush & ~stall_fd;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_aluSrcE   <= 1'b0;
            r_aluOpE    <= 2'b00;
            r_regDstE   <= 2'b00;
            r_regWriteE <= 1'b0;
            r_memWriteE <= 1'b0;
            r_memToRegE <= 1'b0;
            r_memSrcE   <= 1'b0;
            r_muldivE   <= 1'b0;
            r_isDivE    <= 1'b0;
            r_memWriteM <= 1'b0;
            r_regWriteM <= 1'b0;
            r_memToRegM <= 1'b0;
            r_memSrcM   <= 1'b0;
            r_regWriteW <= 1'b0;
            r_memToRegW <= 1'b0;
            r_memSrcW   <= 1'b0;
        end else begin
            r_aluSrcE   <= w_bubble ? 1'b0  : w_aluSrc;
            r_aluOpE    <= w_bubble ? 2'b00 : w_aluOp;
            r_regDstE   <= w_bubble ? 2'b00 : w_regDst;
            r_regWriteE <= w_bubble ? 1'b0  : w_regWrite;
            r_memWriteE <= w_bubble ? 1'b0  : w_memWrite;
            r_memToRegE <= w_bubble ? 1'b0  : w_memToReg;
            r_memSrcE   <= w_bubble ? 1'b0  : w_memSrc;
            r_muldivE   <= w_bubble ? 1'b0  : w_muldiv;
            r_isDivE    <= w_bubble ? 1'b0  : w_isDiv;
            r_memWriteM <= r_memWriteE;
            r_regWriteM <= r_regWriteE;
            r_memToRegM <= r_memToRegE;
            r_memSrcM   <= r_memSrcE;
            r_regWriteW <= r_regWriteM;
            r_memToRegW <= r_memToRegM;
            r_memSrcW   <= r_memSrcM;
        end
    end

    // Busy counter holds remaining cycles minus one; zero marks the last
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (r_muldivE) begin
                        r_state <= c_BUSY;
                        r_cnt   <= r_isDivE ? c_DIV_CNT : c_MULT_CNT;
                    end
                end
                default: begin
                    if (r_cnt == '0) r_state <= c_IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
            endcase
        end
    end

    assign alu_src_e      = r_aluSrcE;
    assign alu_op_e       = r_aluOpE;
    assign reg_dst_e      = r_regDstE;
    assign muldiv_start_e = r_muldivE;
    assign mem_write_m    = r_memWriteM;
    assign reg_write_m    = r_regWriteM;
    assign reg_write_w    = r_regWriteW;
    assign mem_to_reg_w   = r_memToRegW;
    assign memory_src_w   = r_memSrcW;
    assign muldiv_busy    = (r_state == c_BUSY);
    assign muldiv_done    = (r_state == c_BUSY) && (r_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_pipe_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_control_unit
// Brief    : Directed and randomized bench for pipe_control_unit against a
//            cycle-level behavioural model of the control pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_control_unit;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid_d = 1'b0;
    logic [5:0] opcode_d = '0;
    logic [5:0] func_d = '0;
    logic       hazard_stall_d = 1'b0;
    logic       flush_e = 1'b0;
    logic       branch_d, jump_d, if_flush_d, stall_fd, alu_src_e;
    logic [1:0] alu_op_e, reg_dst_e;
    logic       muldiv_start_e, mem_write_m, reg_write_m, reg_write_w;
    logic       mem_to_reg_w, memory_src_w, muldiv_busy, muldiv_done;

    pipe_control_unit #(
        .MULT_LATENCY(MULT_LAT),
        .DIV_LATENCY (DIV_LAT),
        .CNT_W       (4)
    ) dut (
        .clock(clock), .reset(reset), .instr_valid_d(instr_valid_d),
        .opcode_d(opcode_d), .func_d(func_d), .hazard_stall_d(hazard_stall_d),
        .flush_e(flush_e), .branch_d(branch_d), .jump_d(jump_d),
        .if_flush_d(if_flush_d), .stall_fd(stall_fd), .alu_src_e(alu_src_e),
        .alu_op_e(alu_op_e), .reg_dst_e(reg_dst_e),
        .muldiv_start_e(muldiv_start_e), .mem_write_m(mem_write_m),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem_to_reg_w(mem_to_reg_w), .memory_src_w(memory_src_w),
        .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       branch, jump, ifFlush, aluSrc;
        logic [1:0] aluOp, regDst;
        logic       regWrite, memWrite, memToReg, memSrc, muldiv, usesHilo, isDiv;
    } ctrl_t;

    int nChecks = 0;
    int nFail   = 0;

    // Model: words that sit in EX, MEM and WB, plus remaining busy cycles
    ctrl_t mE, mM, mW, mD;
    int    busyLeft = 0;
    logic  mStall, mFlush;
    logic  sStall, sDone, sStart, sBranch, sJump;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ctrl_t decode(input logic v, input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c = '0;
        if (!v) return c;
        case (op)
            6'b000000: begin
                c.regDst = 2'b01; c.aluOp = 2'b10; c.regWrite = 1'b1;
                if (fn == 6'b001000) begin
                    c.jump = 1'b1; c.ifFlush = 1'b1; c.aluOp = 2'b01; c.regWrite = 1'b0;
                end else if (fn inside {6'b011000, 6'b011001, 6'b011010, 6'b011011}) begin
                    c.muldiv = 1'b1; c.regWrite = 1'b0;
                    c.isDiv = (fn == 6'b011010) || (fn == 6'b011011);
                end else if (fn == 6'b010000 || fn == 6'b010010) begin
                    c.usesHilo = 1'b1;
                end
            end
            6'b100011: begin c.aluSrc = 1'b1; c.regWrite = 1'b1; c.memToReg = 1'b1; end
            6'b101011: begin c.aluSrc = 1'b1; c.memWrite = 1'b1; end
            6'b000100: begin c.branch = 1'b1; c.aluOp = 2'b01; end
            6'b000101: begin c.branch = 1'b1; c.aluOp = 2'b11; end
            6'b000010: begin c.jump = 1'b1; c.ifFlush = 1'b1; c.aluSrc = 1'b1; end
            6'b000011: begin
                c.jump = 1'b1; c.ifFlush = 1'b1; c.regDst = 2'b10;
                c.regWrite = 1'b1; c.memSrc = 1'b1;
            end
            default: begin c.aluSrc = 1'b1; c.aluOp = 2'b11; c.regWrite = 1'b1; end
        endcase
        return c;
    endfunction

    task automatic checkNow();
        mD     = decode(instr_valid_d, opcode_d, func_d);
        mStall = hazard_stall_d | ((busyLeft > 0) & (mD.muldiv | mD.usesHilo));
        mFlush = flush_e;
        chk("stall_fd",       stall_fd,       mStall);
        chk("branch_d",       branch_d,       mD.branch & ~mStall);
        chk("jump_d",         jump_d,         mD.jump & ~mStall);
        chk("if_flush_d",     if_flush_d,     mD.ifFlush & ~mStall);
        chk("alu_src_e",      alu_src_e,      mE.aluSrc);
        chk("alu_op_e",       alu_op_e,       mE.aluOp);
        chk("reg_dst_e",      reg_dst_e,      mE.regDst);
        chk("muldiv_start_e", muldiv_start_e, mE.muldiv);
        chk("mem_write_m",    mem_write_m,    mM.memWrite);
        chk("reg_write_m",    reg_write_m,    mM.regWrite);
        chk("reg_write_w",    reg_write_w,    mW.regWrite);
        chk("mem_to_reg_w",   mem_to_reg_w,   mW.memToReg);
        chk("memory_src_w",   memory_src_w,   mW.memSrc);
        chk("muldiv_busy",    muldiv_busy,    busyLeft > 0);
        chk("muldiv_done",    muldiv_done,    busyLeft == 1);
        sStall = stall_fd; sDone = muldiv_done; sStart = muldiv_start_e;
        sBranch = branch_d; sJump = jump_d;
    endtask

    task automatic advance();
        if (busyLeft > 0)   busyLeft--;
        else if (mE.muldiv) busyLeft = mE.isDiv ? DIV_LAT : MULT_LAT;
        mW = mM;
        mM = mE;
        mE = (mStall | mFlush) ? ctrl_t'('0) : mD;
    endtask

    task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic hz, input logic fl);
        instr_valid_d = v; opcode_d = op; func_d = fn;
        hazard_stall_d = hz; flush_e = fl;
        #2;
        checkNow();
        @(posedge clock);
        advance();
        #1;
    endtask

    task automatic clearModel();
        mE = '0; mM = '0; mW = '0; busyLeft = 0;
    endtask

    // Assert reset between edges; registered outputs must clear at once
    task automatic doReset();
        reset = 1'b1;
        #1;
        clearModel();
        chk("rst busy",  muldiv_busy, 1'b0);
        chk("rst done",  muldiv_done, 1'b0);
        chk("rst start", muldiv_start_e, 1'b0);
        checkNow();
        @(posedge clock);
        #1;
        chk("rst done held", muldiv_done, 1'b0);
        reset = 1'b0;
    endtask

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_JAL = 6'b000011;
    localparam logic [5:0] F_MULT = 6'b011000, F_DIV = 6'b011010, F_MFHI = 6'b010000;

    initial begin
        int stallCnt, doneCnt, startCnt;
        logic memSeen;
        logic [5:0] opTab [8];
        logic [5:0] fnTab [8];
        logic v, hz, fl;
        logic [5:0] op, fn;

        clearModel();
        repeat (3) @(posedge clock);
        #1;
        checkNow();
        chk("reset alu_op_e", alu_op_e, 2'b00);
        chk("reset reg_write_w", reg_write_w, 1'b0);
        reset = 1'b0;

        // lw
        step(1, OP_LW, 6'h00, 0, 0);
        chk("lw alu_src_e", alu_src_e, 1'b1);
        chk("lw reg_dst_e", reg_dst_e, 2'b00);
        step(0, 6'h00, 6'h00, 0, 0);
        step(0, 6'h00, 6'h00, 0, 0);
        chk("lw reg_write_w", reg_write_w, 1'b1);
        chk("lw mem_to_reg_w", mem_to_reg_w, 1'b1);

        // jal
        step(1, OP_JAL, 6'h00, 0, 0);
        chk("jal jump_d", sJump, 1'b1);
        chk("jal reg_dst_e", reg_dst_e, 2'b10);
        step(0, 6'h00, 6'h00, 0, 0);
        step(0, 6'h00, 6'h00, 0, 0);
        chk("jal memory_src_w", memory_src_w, 1'b1);
        chk("jal reg_write_w", reg_write_w, 1'b1);

        // mult, then an mfhi held in ID while the unit is busy
        step(1, OP_R, F_MULT, 0, 0);
        chk("mult start", muldiv_start_e, 1'b1);
        step(0, 6'h00, 6'h00, 0, 0);
        chk("mult busy", muldiv_busy, 1'b1);
        stallCnt = 0; doneCnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(1, OP_R, F_MFHI, 0, 0);
            if (sStall) stallCnt++;
            if (sDone) doneCnt++;
            if (!sStall) break;
        end
        chk("mfhi stall cycles", stallCnt, 4);
        chk("mult done pulses", doneCnt, 1);
        chk("mfhi in EX reg_dst", reg_dst_e, 2'b01);
        chk("mfhi in EX no start", muldiv_start_e, 1'b0);

        // div then a dependent div
        step(1, OP_R, F_DIV, 0, 0);
        startCnt = 0; stallCnt = 0;
        step(0, 6'h00, 6'h00, 0, 0);
        startCnt += int'(sStart);
        for (int k = 0; k < 20; k++) begin
            step(1, OP_R, F_DIV, 0, 0);
            startCnt += int'(sStart);
            if (sStall) stallCnt++;
            if (!sStall) break;
        end
        for (int k = 0; k < 10; k++) begin
            step(0, 6'h00, 6'h00, 0, 0);
            startCnt += int'(sStart);
        end
        chk("div stall cycles", stallCnt, 8);
        chk("div start pulses", startCnt, 2);

        // beq behind a two-cycle load-use stall, then flushed and normal sw
        step(1, OP_BEQ, 6'h00, 1, 0);
        chk("beq stalled branch_d", sBranch, 1'b0);
        chk("beq bubble 1", alu_op_e, 2'b00);
        step(1, OP_BEQ, 6'h00, 1, 0);
        chk("beq bubble 2", alu_op_e, 2'b00);
        step(1, OP_BEQ, 6'h00, 0, 0);
        chk("beq branch_d", sBranch, 1'b1);
        chk("beq alu_op_e", alu_op_e, 2'b01);
        memSeen = 1'b0;
        step(1, OP_SW, 6'h00, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 6'h00, 6'h00, 0, 0);
            memSeen |= mem_write_m;
        end
        chk("flushed sw mem_write", memSeen, 1'b0);
        step(1, OP_SW, 6'h00, 0, 0);
        step(0, 6'h00, 6'h00, 0, 0);
        chk("sw mem_write_m", mem_write_m, 1'b1);

        // reset in the third busy cycle of a div
        step(1, OP_R, F_DIV, 0, 0);
        step(1, OP_LW, 6'h00, 0, 0);
        step(1, OP_LW, 6'h00, 0, 0);
        step(1, OP_LW, 6'h00, 0, 0);
        chk("pre-reset busy", muldiv_busy, 1'b1);
        chk("pre-reset alu_src_e", alu_src_e, 1'b1);
        doReset();
        chk("post-reset busy", muldiv_busy, 1'b0);
        chk("post-reset mem_to_reg_w", mem_to_reg_w, 1'b0);

        // randomized traffic
        opTab = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                  6'b000101, 6'b000010, 6'b000011, 6'b001000};
        fnTab = '{6'b001000, 6'b011000, 6'b011001, 6'b011010,
                  6'b011011, 6'b010000, 6'b010010, 6'b100000};
        v = 1'b0; op = '0; fn = '0;
        for (int n = 0; n < 1500; n++) begin
            if (n % 200 == 199) doReset();
            if (!(sStall && ($urandom % 4 != 0))) begin
                v  = ($urandom % 8) != 0;
                op = ($urandom % 6 == 0) ? 6'($urandom) : opTab[$urandom % 8];
                if (op == 6'b000000 && ($urandom % 3 != 0)) op = 6'b000000;
                fn = ($urandom % 6 == 0) ? 6'($urandom) : fnTab[$urandom % 8];
            end
            hz = ($urandom % 7) == 0;
            fl = ($urandom % 9) == 0;
            step(v, op, fn, hz, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
